// File: rtl/matmul_c_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// matmul_c_result_collector_pkg
//   Shared constants and the collector state type for the C-output sink of
//   the composed systolic matmul.
//   DWIDTH          : bits per matrix element
//   BB_MAT_MUL_SIZE : elements per row (lanes per stream word)
//   AWIDTH          : C scratchpad address width
//   state_t         : collector FSM states
// ---------------------------------------------------------------------------
package matmul_c_result_collector_pkg;

  localparam int DWIDTH          = 8;
  localparam int BB_MAT_MUL_SIZE = 8;
  localparam int AWIDTH          = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/matmul_c_result_collector_fifo.sv
// ---------------------------------------------------------------------------
// matmul_c_fifo
//   Single-clock FIFO buffering one result stream ahead of the C write port.
//   A push and a pop in the same cycle are both honoured, also when full.
//   Ports:
//     clk, reset : clock, async active-high reset
//     flush_i    : empties the FIFO (wins over push/pop)
//     push_i     : write din_i (ignored when full unless popping too)
//     pop_i      : consume the head entry (ignored when empty)
//     din_i      : entry to write
//     dout_o     : head entry (valid while !empty_o)
//     full_o     : no free slot
//     empty_o    : no stored entry
// ---------------------------------------------------------------------------
module matmul_c_fifo #(
  parameter int WIDTH = 74,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             doPush;
  logic             doPop;

  // A pop frees the head slot in the same edge, so a full FIFO may still take
  // a push when it is also being popped.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign dout_o  = mem_q[rdPtr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/matmul_c_result_collector.sv
// ---------------------------------------------------------------------------
// matmul_c_result_collector
//   Collects the two per-tile-row result streams of the systolic matmul,
//   buffers each in a FIFO and merges them round-robin onto the single C
//   scratchpad write port. Counts row writes and reports done/error status.
//   Ports:
//     clk, reset         : clock, async active-high reset
//     start              : 1-cycle pulse, begin collecting a new matmul
//     s0_* / s1_*        : stream rows (data, address, valid; no backpressure)
//     c_wr_en/addr/data  : registered C RAM write port
//     done               : all NUM_WRITES writes issued (level)
//     busy               : collecting
//     overflow_err       : sticky, a row was dropped on a full FIFO
//     unexpected_err     : sticky, a row arrived while not collecting
// ---------------------------------------------------------------------------
module matmul_c_result_collector
  import matmul_c_result_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_WRITES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] s0_data,
  input  logic [AWIDTH-1:0]                 s0_addr,
  input  logic                              s0_available,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] s1_data,
  input  logic [AWIDTH-1:0]                 s1_addr,
  input  logic                              s1_available,
  output logic                              c_wr_en,
  output logic [AWIDTH-1:0]                 c_wr_addr,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_wr_data,
  output logic                              done,
  output logic                              busy,
  output logic                              overflow_err,
  output logic                              unexpected_err
);

  localparam int DW = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int EW = AWIDTH + DW;
  localparam int CW = $clog2(NUM_WRITES + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rr_q, rr_d;
  logic            ovf_q, ovf_d;
  logic            unx_q, unx_d;
  logic            wrEn_q;
  logic [AWIDTH-1:0] wrAddr_q;
  logic [DW-1:0]   wrData_q;

  logic            collecting;
  logic            push0, push1, pop0, pop1;
  logic            full0, full1, empty0, empty1;
  logic [EW-1:0]   dout0, dout1, popEntry;

  // The start cycle itself belongs to the old run: nothing is captured or
  // popped while the FIFOs are being flushed.
  assign collecting = (state_q == COLLECT) && !start;

  matmul_c_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .flush_i(start),
    .push_i(push0), .pop_i(pop0), .din_i({s0_addr, s0_data}),
    .dout_o(dout0), .full_o(full0), .empty_o(empty0)
  );

  matmul_c_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .flush_i(start),
    .push_i(push1), .pop_i(pop1), .din_i({s1_addr, s1_data}),
    .dout_o(dout1), .full_o(full1), .empty_o(empty1)
  );

  // Arbitration: a lone non-empty FIFO is always served; when both hold rows
  // the round-robin pointer picks and then flips to the other stream.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    rr_d = rr_q;
    if (collecting) begin
      if (!empty0 && !empty1) begin
        pop0 = !rr_q;
        pop1 = rr_q;
        rr_d = !rr_q;
      end else if (!empty0) begin
        pop0 = 1'b1;
      end else if (!empty1) begin
        pop1 = 1'b1;
      end
    end
    if (start) rr_d = 1'b0;
  end

  assign push0    = collecting && s0_available && (!full0 || pop0);
  assign push1    = collecting && s1_available && (!full1 || pop1);
  assign popEntry = pop1 ? dout1 : dout0;

  // Next-state, counter and sticky error flags. A stray row seen during the
  // start cycle is flagged after the restart clear, so it is not lost.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unx_d   = unx_q;
    if (start) begin
      state_d = COLLECT;
      count_d = '0;
      ovf_d   = 1'b0;
      unx_d   = 1'b0;
    end else if (pop0 || pop1) begin
      count_d = count_q + 1'b1;
      if (count_q == CW'(NUM_WRITES - 1)) state_d = DONE;
    end
    if (collecting && s0_available && full0 && !pop0) ovf_d = 1'b1;
    if (collecting && s1_available && full1 && !pop1) ovf_d = 1'b1;
    if (!collecting && (s0_available || s1_available)) unx_d = 1'b1;
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
      unx_q   <= unx_d;
    end
  end

  // Write port: strobe for one cycle per pop, address/data hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      wrEn_q <= pop0 || pop1;
      if (pop0 || pop1) {wrAddr_q, wrData_q} <= popEntry;
    end
  end

  assign c_wr_en        = wrEn_q;
  assign c_wr_addr      = wrAddr_q;
  assign c_wr_data      = wrData_q;
  assign done           = (state_q == DONE);
  assign busy           = (state_q == COLLECT);
  assign overflow_err   = ovf_q;
  assign unexpected_err = unx_q;

endmodule
